// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: func codes, FSM states
// and a small operand helper used when preparing divider magnitudes.
package md_pkg;

  localparam logic [2:0] MD_MULT = 3'b001;
  localparam logic [2:0] MD_DIV  = 3'b010;
  localparam logic [2:0] MD_MTHI = 3'b011;
  localparam logic [2:0] MD_MTLO = 3'b100;

  localparam int unsigned DIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_sign);
    return (is_sign && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer bundle; master is the pipeline side.
interface md_sequencer_if;
  logic        start;
  logic [2:0]  func;
  logic        is_sign;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        read_hi;
  logic        read_lo;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  modport master (
    output start, func, is_sign, op_a, op_b, flush, read_hi, read_lo,
    input  busy, stall, hi, lo, done
  );

  modport slave (
    input  start, func, is_sign, op_a, op_b, flush, read_hi, read_lo,
    output busy, stall, hi, lo, done
  );
endinterface

// File: rtl/md_div_iter.sv
// 32-step restoring unsigned divider. done_o marks the cycle whose closing edge
// commits the last step; quotient_o/remainder_o carry that step's results.
module md_div_iter
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        clear_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;

  logic [32:0] shifted;
  logic        fits;

  always_comb begin
    // Partial remainder shifted left, pulling in the next dividend bit
    shifted     = {rem_q, quo_q[31]};
    fits        = (shifted >= {1'b0, dvs_q});
    quotient_o  = {quo_q[30:0], fits};
    remainder_o = fits ? (shifted[31:0] - dvs_q) : shifted[31:0];

    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      rem_d = '0;
      quo_d = '0;
      dvs_d = '0;
      cnt_d = '0;
    end else if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = 6'(DIV_STEPS);
    end else if (cnt_q != 6'd0) begin
      rem_d = remainder_o;
      quo_d = quotient_o;
      cnt_d = cnt_q - 6'd1;
    end
  end

  assign done_o = (cnt_q == 6'd1) && !clear_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: counter-released multiply, iterative divide
// with sign fix-up and zero/overflow handling, single-cycle mthi/mtlo.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic           clk,
  input  logic           rst,
  md_sequencer_if.slave  md
);

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sign_q, sign_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        busy;
  logic        accept;
  logic        div_start;
  logic        div_clear;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic [63:0]        product;

  logic        q_neg;
  logic        r_neg;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        div_by_zero;
  logic        div_ovf;

  assign busy      = (state_q != IDLE);
  assign accept    = (state_q == IDLE) && md.start && !md.flush;
  assign div_start = accept && (md.func == MD_DIV);
  assign div_clear = md.flush && busy;

  md_div_iter u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .clear_i     (div_clear),
    .dividend_i  (mag32(md.op_a, md.is_sign)),
    .divisor_i   (mag32(md.op_b, md.is_sign)),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // 33-bit extension lets one signed multiplier serve both signednesses
  assign mul_a   = {sign_q & a_q[31], a_q};
  assign mul_b   = {sign_q & b_q[31], b_q};
  assign product = 64'(mul_a) * 64'(mul_b);

  assign q_neg       = sign_q && (a_q[31] ^ b_q[31]);
  assign r_neg       = sign_q && a_q[31];
  assign quo_fix     = q_neg ? (~div_quo + 32'd1) : div_quo;
  assign rem_fix     = r_neg ? (~div_rem + 32'd1) : div_rem;
  assign div_by_zero = (b_q == 32'd0);
  assign div_ovf     = sign_q && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (md.func == MD_MULT) begin
            a_d     = md.op_a;
            b_d     = md.op_b;
            sign_d  = md.is_sign;
            cnt_d   = 6'(MUL_CYCLES);
            state_d = MUL;
          end else if (md.func == MD_DIV) begin
            a_d     = md.op_a;
            b_d     = md.op_b;
            sign_d  = md.is_sign;
            cnt_d   = 6'(DIV_CYCLES);
            state_d = DIV;
          end else if (md.func == MD_MTHI) begin
            hi_d = md.op_a;
          end else if (md.func == MD_MTLO) begin
            lo_d = md.op_a;
          end
        end
      end

      MUL: begin
        if (md.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 6'd1) begin
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      DIV: begin
        if (md.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (div_done) begin
          if (div_by_zero) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else if (div_ovf) begin
            hi_d = 32'd0;
            lo_d = 32'h8000_0000;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign md.busy  = busy;
  assign md.stall = busy && (md.start || md.read_hi || md.read_lo);
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
  assign md.done  = done_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: expected HI/LO pushed at issue, popped on done.
module tb_md_sequencer;
  import md_pkg::*;

  localparam int NMUL = 5;
  localparam int NDIV = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  md_sequencer_if mif ();

  md_sequencer #(.MUL_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
    .clk (clk),
    .rst (rst),
    .md  (mif)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    if (s) begin
      sa  = 64'($signed(a));
      sbv = 64'($signed(b));
      return 64'(sa * sbv);
    end
    return 64'(a) * 64'(b);
  endfunction

  function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa  = a;
      sbv = b;
      q   = 32'(sa / sbv);
      r   = 32'(sa % sbv);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic drive(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
    mif.start   = 1'b1;
    mif.func    = f;
    mif.is_sign = s;
    mif.op_a    = a;
    mif.op_b    = b;
  endtask

  // Called at the negedge of cycle 1 after acceptance; returns at cycle N+1.
  task automatic wait_result(input string tag, input int n);
    int   cycles;
    logic early;
    exp_t e;
    cycles = 0;
    early  = 1'b0;
    while (mif.busy && cycles < 100) begin
      if (mif.done) early = 1'b1;
      @(negedge clk);
      cycles++;
    end
    check({tag, " busy_cycles"}, 64'(cycles), 64'(n));
    check({tag, " early_done"}, 64'(early), 64'd0);
    check({tag, " done"}, 64'(mif.done), 64'd1);
    check({tag, " sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, " hilo"}, {mif.hi, mif.lo}, {e.hi, e.lo});
      $display("txn %s hi=%h lo=%h busy_cycles=%0d", e.tag, mif.hi, mif.lo, cycles);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic s,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [63:0] want);
    exp_t e;
    drive(f, s, a, b);
    e.tag = tag;
    e.hi  = want[63:32];
    e.lo  = want[31:0];
    sb.push_back(e);
    @(negedge clk);
    mif.start = 1'b0;
    mif.op_a  = $urandom;
    mif.op_b  = $urandom;
    wait_result(tag, n);
    @(negedge clk);
    check({tag, " done_clear"}, 64'(mif.done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        seen;
    int          cyc;
    exp_t        e;

    rst         = 1'b0;
    mif.start   = 1'b0;
    mif.func    = 3'b000;
    mif.is_sign = 1'b0;
    mif.op_a    = '0;
    mif.op_b    = '0;
    mif.flush   = 1'b0;
    mif.read_hi = 1'b1;
    mif.read_lo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(mif.busy), 64'd0);
    check("rst hilo", {mif.hi, mif.lo}, 64'd0);
    check("rst done", 64'(mif.done), 64'd0);
    check("rst stall", 64'(mif.stall), 64'd0);
    mif.read_hi = 1'b0;

    // First op presented while reset releases: accepted on first edge with rst high
    rst = 1'b1;
    run_op("mult_s_m3x7", MD_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, NMUL, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mult_u_max", MD_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NMUL, 64'hFFFF_FFFE_0000_0001);
    run_op("div_s_m7d2", MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, NDIV, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_u_m7d2", MD_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, NDIV, 64'h0000_0001_7FFF_FFFC);
    run_op("div_5d0", MD_DIV, 1'b0, 32'd5, 32'd0, NDIV, 64'h0000_0005_FFFF_FFFF);
    run_op("div_s_m7d0", MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd0, NDIV, 64'hFFFF_FFF9_FFFF_FFFF);
    run_op("div_s_ovf", MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, NDIV, 64'h0000_0000_8000_0000);
    run_op("div_s_m100d7n", MD_DIV, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, NDIV, 64'hFFFF_FFFE_0000_000E);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op($sformatf("mult_rand%0d", i), MD_MULT, 1'(i % 2), ra, rb, NMUL, mul_model(1'(i % 2), ra, rb));
      rb = $urandom_range(1, 5000);
      if (i >= 2) rb = ~rb;
      run_op($sformatf("div_rand%0d", i), MD_DIV, 1'(i % 2), ra, rb, NDIV, div_model(1'(i % 2), ra, rb));
    end

    // Read hazard stalls until busy drops; a held start is taken in the done cycle
    drive(MD_MULT, 1'b0, 32'd6, 32'd7);
    e.tag = "b2b_first"; e.hi = 32'd0; e.lo = 32'd42;
    sb.push_back(e);
    @(negedge clk);
    drive(MD_MULT, 1'b0, 32'd3, 32'd5);
    check("b2b stall_start_c1", 64'(mif.stall), 64'd1);
    @(negedge clk);
    mif.read_lo = 1'b1;
    cyc  = 1;
    seen = 1'b0;
    while (mif.busy && cyc < 100) begin
      if (mif.stall !== 1'b1) seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("b2b busy_end", 64'(cyc), 64'(NMUL));
    check("b2b stall_held", 64'(seen), 64'd0);
    check("b2b stall_release", 64'(mif.stall), 64'd0);
    check("b2b done", 64'(mif.done), 64'd1);
    e = sb.pop_front();
    check("b2b first_hilo", {mif.hi, mif.lo}, {e.hi, e.lo});
    $display("txn %s hi=%h lo=%h", e.tag, mif.hi, mif.lo);
    e.tag = "b2b_second"; e.hi = 32'd0; e.lo = 32'd15;
    sb.push_back(e);
    @(negedge clk);
    mif.start   = 1'b0;
    mif.read_lo = 1'b0;
    mif.op_a    = 32'd1000;
    wait_result("b2b_second", NMUL);
    @(negedge clk);

    // Flush in cycle 10 of a divide
    drive(MD_DIV, 1'b0, 32'd1000, 32'd3);
    @(negedge clk);
    mif.start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush busy_c10", 64'(mif.busy), 64'd1);
    mif.flush = 1'b1;
    @(negedge clk);
    mif.flush = 1'b0;
    check("flush busy_c11", 64'(mif.busy), 64'd0);
    check("flush hilo_kept", {mif.hi, mif.lo}, 64'd15);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mif.done) seen = 1'b1;
      @(negedge clk);
    end
    check("flush no_done", 64'(seen), 64'd0);
    $display("txn flush_div hi=%h lo=%h", mif.hi, mif.lo);

    // Single-cycle moves, flush-suppressed move, reserved func
    drive(MD_MTHI, 1'b0, 32'h1234_5678, 32'd0);
    @(negedge clk);
    mif.start = 1'b0;
    check("mthi hilo", {mif.hi, mif.lo}, 64'h1234_5678_0000_000F);
    check("mthi busy", 64'(mif.busy), 64'd0);
    check("mthi done", 64'(mif.done), 64'd0);
    $display("txn mthi hi=%h lo=%h", mif.hi, mif.lo);
    drive(MD_MTLO, 1'b0, 32'hCAFE_BABE, 32'd0);
    @(negedge clk);
    mif.start = 1'b0;
    check("mtlo hilo", {mif.hi, mif.lo}, 64'h1234_5678_CAFE_BABE);
    $display("txn mtlo hi=%h lo=%h", mif.hi, mif.lo);
    drive(MD_MTLO, 1'b0, 32'hDEAD_BEEF, 32'd0);
    mif.flush = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    mif.flush = 1'b0;
    check("mtlo_flushed hilo", {mif.hi, mif.lo}, 64'h1234_5678_CAFE_BABE);
    $display("txn mtlo_flushed hi=%h lo=%h", mif.hi, mif.lo);
    drive(3'b111, 1'b0, 32'h1111_1111, 32'd3);
    @(negedge clk);
    mif.func = 3'b000;
    @(negedge clk);
    mif.start = 1'b0;
    check("reserved hilo", {mif.hi, mif.lo}, 64'h1234_5678_CAFE_BABE);
    check("reserved busy", 64'(mif.busy), 64'd0);
    $display("txn reserved hi=%h lo=%h", mif.hi, mif.lo);

    // Asynchronous reset in the middle of a divide
    drive(MD_DIV, 1'b0, 32'd77, 32'd4);
    @(negedge clk);
    mif.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid busy", 64'(mif.busy), 64'd0);
    check("rst_mid hilo", {mif.hi, mif.lo}, 64'd0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mif.done || mif.busy) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_mid no_done", 64'(seen), 64'd0);
    $display("txn rst_mid_div hi=%h lo=%h", mif.hi, mif.lo);
    run_op("div_after_rst", MD_DIV, 1'b0, 32'd100, 32'd7, NDIV, 64'h0000_0002_0000_000E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
